// File: rtl/exe_stage_pipe_if.sv
// EXE stage bundle: ID/EXE inputs, forwarding selects,
// stall controls and the registered EXE/MEM outputs.
interface exe_stage_pipe_if;
  logic        freeze;
  logic        flush;
  logic [3:0]  exe_cmd;
  logic        s;
  logic        imm;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        wb_en;
  logic [11:0] shift_operand;
  logic [23:0] signed_imm_24;
  logic [31:0] pc;
  logic [31:0] val_rn;
  logic [31:0] val_rm;
  logic [3:0]  dest;
  logic [1:0]  sel_src1;
  logic [1:0]  sel_src2;
  logic [31:0] wb_value;
  logic [31:0] alu_result_out;
  logic [31:0] st_val_out;
  logic [3:0]  dest_out;
  logic        wb_en_out;
  logic        mem_r_en_out;
  logic        mem_w_en_out;
  logic [3:0]  status;
  logic [31:0] branch_address;

  modport master (
    output freeze, flush, exe_cmd, s, imm,
    output mem_r_en, mem_w_en, wb_en,
    output shift_operand, signed_imm_24, pc,
    output val_rn, val_rm, dest,
    output sel_src1, sel_src2, wb_value,
    input  alu_result_out, st_val_out, dest_out,
    input  wb_en_out, mem_r_en_out, mem_w_en_out,
    input  status, branch_address
  );

  modport slave (
    input  freeze, flush, exe_cmd, s, imm,
    input  mem_r_en, mem_w_en, wb_en,
    input  shift_operand, signed_imm_24, pc,
    input  val_rn, val_rm, dest,
    input  sel_src1, sel_src2, wb_value,
    output alu_result_out, st_val_out, dest_out,
    output wb_en_out, mem_r_en_out, mem_w_en_out,
    output status, branch_address
  );
endinterface

// File: rtl/exe_stage_pipe.sv
// ARM execute stage: operand forwarding, shifter, ALU,
// branch target, EXE/MEM register and NZCV register.
module exe_stage_pipe #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  exe_stage_pipe_if.slave bus
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  logic [WIDTH-1:0]   op1;
  logic [WIDTH-1:0]   op_rm;
  logic [WIDTH-1:0]   val2;
  logic [WIDTH-1:0]   imm32;
  logic [2*WIDTH-1:0] rot_w;
  logic [4:0]         rot_amt;
  logic [4:0]         sh_amt;
  logic [WIDTH-1:0]   b_op;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res;
  logic               arith;
  logic               known;
  logic [3:0]         nzcv;
  logic               flag_c;
  logic [WIDTH-1:0]   br_off;
  logic               unused;

  // Bit 4 selects register-specified shift amounts, which
  // this stage never executes.
  assign unused = bus.shift_operand[4];

  assign flag_c = bus.status[1];

  // Forwarding mux for the first operand
  always_comb begin
    op1 = bus.val_rn;
    case (bus.sel_src1)
      2'b01:   op1 = bus.alu_result_out;
      2'b10:   op1 = bus.wb_value;
      default: op1 = bus.val_rn;
    endcase
  end

  // Forwarding mux for Rm (shifter input and store data)
  always_comb begin
    op_rm = bus.val_rm;
    case (bus.sel_src2)
      2'b01:   op_rm = bus.alu_result_out;
      2'b10:   op_rm = bus.wb_value;
      default: op_rm = bus.val_rm;
    endcase
  end

  // Val2: rotated immediate, memory offset or shifted Rm
  always_comb begin
    rot_amt = {bus.shift_operand[11:8], 1'b0};
    sh_amt  = bus.shift_operand[11:7];
    imm32   = {24'd0, bus.shift_operand[7:0]};
    rot_w   = '0;
    val2    = op_rm;
    if (bus.imm) begin
      rot_w = {imm32, imm32} >> rot_amt;
      val2  = rot_w[WIDTH-1:0];
    end else if (bus.mem_r_en || bus.mem_w_en) begin
      val2 = {20'd0, bus.shift_operand};
    end else begin
      case (bus.shift_operand[6:5])
        2'b00: val2 = op_rm << sh_amt;
        2'b01: val2 = op_rm >> sh_amt;
        2'b10: val2 = $signed(op_rm) >>> sh_amt;
        default: begin
          rot_w = {op_rm, op_rm} >> sh_amt;
          val2  = rot_w[WIDTH-1:0];
        end
      endcase
    end
  end

  // ALU: one shared adder for ADD/ADC/SUB/SBC,
  // subtract done as op1 + ~val2 + carry-in
  always_comb begin
    b_op  = val2;
    cin   = 1'b0;
    arith = 1'b0;
    known = 1'b1;
    res   = '0;
    unique case (bus.exe_cmd)
      CMD_ADD: arith = 1'b1;
      CMD_ADC: begin
        arith = 1'b1;
        cin   = flag_c;
      end
      CMD_SUB: begin
        arith = 1'b1;
        b_op  = ~val2;
        cin   = 1'b1;
      end
      CMD_SBC: begin
        arith = 1'b1;
        b_op  = ~val2;
        cin   = flag_c;
      end
      default: ;
    endcase
    sum = {1'b0, op1} + {1'b0, b_op}
        + {{WIDTH{1'b0}}, cin};
    unique case (bus.exe_cmd)
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD, CMD_ADC,
      CMD_SUB, CMD_SBC: res = sum[WIDTH-1:0];
      CMD_AND: res = op1 & val2;
      CMD_ORR: res = op1 | val2;
      CMD_EOR: res = op1 ^ val2;
      default: begin
        res   = '0;
        known = 1'b0;
      end
    endcase
  end

  // Next NZCV: C/V only change on arithmetic commands
  always_comb begin
    nzcv = bus.status;
    if (known) begin
      nzcv[3] = res[WIDTH-1];
      nzcv[2] = (res == '0);
      if (arith) begin
        nzcv[1] = sum[WIDTH];
        nzcv[0] = (op1[WIDTH-1] == b_op[WIDTH-1])
               && (res[WIDTH-1] != op1[WIDTH-1]);
      end
    end
  end

  // Branch target from the word-aligned signed offset
  always_comb begin
    br_off = {{6{bus.signed_imm_24[23]}},
              bus.signed_imm_24, 2'b00};
    bus.branch_address = bus.pc + br_off;
  end

  // Status register: held on stall or bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus.status <= 4'b0000;
    else if (bus.s && !bus.freeze && !bus.flush)
      bus.status <= nzcv;
  end

  // EXE/MEM register: freeze holds, flush inserts a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.alu_result_out <= '0;
      bus.st_val_out     <= '0;
      bus.dest_out       <= '0;
      bus.wb_en_out      <= 1'b0;
      bus.mem_r_en_out   <= 1'b0;
      bus.mem_w_en_out   <= 1'b0;
    end else if (bus.freeze) begin
      bus.alu_result_out <= bus.alu_result_out;
    end else if (bus.flush) begin
      bus.alu_result_out <= '0;
      bus.st_val_out     <= '0;
      bus.dest_out       <= '0;
      bus.wb_en_out      <= 1'b0;
      bus.mem_r_en_out   <= 1'b0;
      bus.mem_w_en_out   <= 1'b0;
    end else begin
      bus.alu_result_out <= res;
      bus.st_val_out     <= op_rm;
      bus.dest_out       <= bus.dest;
      bus.wb_en_out      <= bus.wb_en;
      bus.mem_r_en_out   <= bus.mem_r_en;
      bus.mem_w_en_out   <= bus.mem_w_en;
    end
  end

endmodule

// File: doc/exe_stage_pipe.md
Name: exe_stage_pipe

Overview:
- Execute stage of the 5-stage ARM pipeline, plus the EXE/MEM pipeline register and the NZCV status register.
- Consumes the ID/EXE register outputs and the 2-bit operand-select codes produced by the forwarding unit.
- Selects forwarded operands, generates Val2 (shifter operand), runs the ALU and computes the branch target.
- Registers the results toward MEM. The registered outputs are the mem_dest/mem_wb_en/mem_alu_result the forwarding path uses.

Parameters:
- WIDTH, 32, datapath width (fixed by the ARM ISA; only 32 is supported).

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  hold EXE/MEM register and status register (memory stall)
- flush  in  1  convert captured instruction into a bubble
- exe_cmd  in  4  ALU command
- s  in  1  update status flags
- imm  in  1  Val2 is a rotated immediate
- mem_r_en, mem_w_en, wb_en  in  1 each  control bits from ID/EXE
- shift_operand  in  12  ARM shifter operand field
- signed_imm_24  in  24  branch offset
- pc  in  32  PC+4 of this instruction
- val_rn, val_rm  in  32 each  register-file operands
- dest  in  4  destination register
- sel_src1, sel_src2  in  2 each  forwarding selects: 00 register file, 01 MEM-stage ALU result, 10 WB value
- wb_value  in  32  write-back stage data
- alu_result_out  out  32  registered ALU result (also MEM-stage forwarding source)
- st_val_out  out  32  registered store data (forwarded Rm)
- dest_out  out  4  registered dest
- wb_en_out, mem_r_en_out, mem_w_en_out  out  1 each  registered controls
- status  out  4  NZCV register {N,Z,C,V}
- branch_address  out  32  combinational: pc + (sext(signed_imm_24) << 2)

Behaviour:
- Reset (async): all registered outputs and status = 0.
- Operand mux:
  - op1 = val_rn, alu_result_out or wb_value per sel_src1.
  - op_rm = the same three sources per sel_src2.
  - Select 11 behaves as 00.
- Val2:
  - If imm: zero-extend shift_operand[7:0], rotate right by 2×shift_operand[11:8].
  - Else if mem_r_en|mem_w_en: zero-extend shift_operand[11:0].
  - Else: shift op_rm by shift_operand[11:7] using type shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - Shift amount 0 returns op_rm unchanged for all types.
- ALU (exe_cmd):
  - 0001 MOV = Val2; 1001 MVN = ~Val2.
  - 0010 ADD; 0011 ADC (+C from status); 0100 SUB/CMP = op1−Val2; 0101 SBC = op1−Val2−!C.
  - 0110 AND/TST; 0111 ORR; 1000 EOR.
  - Other codes: result 0, flags unchanged.
- Flags:
  - N = res[31]; Z = (res == 0).
  - Arithmetic: C = carry out of the 33-bit sum (for subtract, C = NOT borrow); V = signed overflow.
  - Logical and MOV/MVN: C and V keep their previous values.
- Status register: loads new NZCV on a rising edge when s=1 and freeze=0 and flush=0.
- EXE/MEM register, 1-cycle latency, priority rst > freeze > flush > load:
  - freeze=1: hold all outputs.
  - flush=1 (no freeze): wb_en_out, mem_r_en_out, mem_w_en_out = 0; data fields don't care, implemented as 0.
  - Otherwise: capture alu result, op_rm, dest and controls.
- Forwarding loop: alu_result_out is read in the same cycle it feeds the mux. The value used is the pre-edge register value; no combinational loop.
- Reset mid-operation: all in-flight state is lost and outputs read as a bubble on the next cycle.

Test Plan:
- Reset: rst=1 with arbitrary inputs -> all outputs 0, status 0000; async assertion clears without a clock edge.
- ADD with forwarding:
  - Setup: val_rn=5, sel_src1=01, previous alu_result_out=100, imm=1, shift_operand=0x002, exe_cmd=0010, s=1, wb_en=1, dest=3.
  - Expected next cycle: alu_result_out=102, dest_out=3, wb_en_out=1, status=0000.
- SUB flags: op1=3, imm Val2=3, exe_cmd=0100, s=1 -> result 0, status N0 Z1 C1 V0. Then op1=0x7FFFFFFF, Val2=0xFFFFFFFF (MVN 0) with ADD -> 0x7FFFFFFE, C=1, V=0.
- Shifter:
  - shift_operand={5'd4,2'b10,1'b0,4'dx}, op_rm=0x80000000, MOV -> 0xF8000000.
  - ROR 8 of 0x000000FF -> 0xFF000000.
  - imm with rotate 1 on 0xFF -> 0xC000003F.
- Freeze/flush:
  - freeze=1 with a new ADD presented -> outputs and status unchanged for 3 cycles.
  - Then flush=1 -> wb_en_out=mem_r_en_out=mem_w_en_out=0 and status unchanged despite s=1.
- Branch and ADC: signed_imm_24=0xFFFFFE, pc=0x100 -> branch_address=0xF8. With C=1, ADC 1+1 -> 3.
